// File: rtl/load_store_queue_pkg.sv
// Shared types and constants for the in-order load/store queue.
package load_store_queue_pkg;

   typedef enum logic {
      LSQ_STATE_IDLE = 1'b0,
      LSQ_STATE_BUSY = 1'b1
   } lsq_state_e;

   localparam logic [1:0] LSU_SIZE_B = 2'b00;
   localparam logic [1:0] LSU_SIZE_H = 2'b01;
   localparam logic [1:0] LSU_SIZE_W = 2'b10;

   // funct3 bit that selects zero-extension on loads
   localparam int LSU_F3_UNSIGNED = 2;

   localparam int LSQ_XLEN = 32;

   typedef struct packed {
      logic                is_load;
      logic [2:0]          funct3;
      logic [4:0]          regd_addr;
      logic [LSQ_XLEN-1:0] regs2_data;
      logic [LSQ_XLEN-1:0] addr;
   } lsq_entry_t;

endpackage

// File: rtl/load_store_queue_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop happens on the same edge.
module load_store_queue_fifo #(
   parameter int C_WIDTH   = 8,
   parameter int C_DEPTH_X = 2
) (
   input  logic               clk_i,
   input  logic               resetb_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [C_WIDTH-1:0] wdata_i,
   output logic [C_WIDTH-1:0] rdata_o,
   output logic [C_DEPTH_X:0] count_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int unsigned DEPTH = 2**C_DEPTH_X;

   logic [C_WIDTH-1:0]   mem_q [DEPTH];
   logic [C_DEPTH_X-1:0] wr_ptr_q, rd_ptr_q;
   logic [C_DEPTH_X:0]   count_q;
   logic                 push_ok, pop_ok;

   assign full_o  = (count_q == (C_DEPTH_X+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (!resetb_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (resetb_i) begin
         assert (!(push_i && full_o && !pop_ok))
            else $error("lsq fifo: push dropped while full");
      end
   end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: buffers execute-stage accesses and issues them one at a
// time on a req/ack data-memory port, returning extended load data to the register file.
module load_store_queue
   import load_store_queue_pkg::*;
#(
   parameter int C_XLEN_X  = 5,
   parameter int C_XLEN    = 2**C_XLEN_X,
   parameter int C_DEPTH_X = 2
) (
   input  logic              clk_i,
   input  logic              resetb_i,
   input  logic              clk_en_i,
   input  logic              exs_lq_wr_i,
   input  logic              exs_sq_wr_i,
   input  logic [2:0]        exs_funct3_i,
   input  logic [4:0]        exs_regd_addr_i,
   input  logic [C_XLEN-1:0] exs_regs2_data_i,
   input  logic [C_XLEN-1:0] exs_addr_i,
   output logic              exs_full_o,
   output logic              lsq_empty_o,
   output logic              dmem_req_o,
   output logic              dmem_wr_o,
   output logic [C_XLEN-1:0] dmem_addr_o,
   output logic [3:0]        dmem_byte_en_o,
   output logic [C_XLEN-1:0] dmem_wdata_o,
   input  logic              dmem_ack_i,
   input  logic [C_XLEN-1:0] dmem_rdata_i,
   output logic              wb_regd_wr_o,
   output logic [4:0]        wb_regd_addr_o,
   output logic [C_XLEN-1:0] wb_regd_data_o
);

   localparam int ENTRY_W = $bits(lsq_entry_t);

   lsq_state_e         state_q;
   lsq_entry_t         push_entry, head;
   logic [ENTRY_W-1:0] head_raw;
   logic [C_DEPTH_X:0] count;
   logic               fifo_full, fifo_empty;
   logic               push, pop, busy, last_entry;
   logic               wb_regd_wr_q;
   logic [4:0]         wb_regd_addr_q;
   logic [C_XLEN-1:0]  wb_regd_data_q, wb_regd_data_d;

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         LSU_SIZE_B: return 4'b0001 << off;
         LSU_SIZE_H: return 4'b0011 << {off[1], 1'b0};
         default:    return 4'b1111;
      endcase
   endfunction

   function automatic logic [C_XLEN-1:0] lane_wdata(input logic [1:0] size,
                                                    input logic [C_XLEN-1:0] d);
      case (size)
         LSU_SIZE_B: return {4{d[7:0]}};
         LSU_SIZE_H: return {2{d[15:0]}};
         default:    return d;
      endcase
   endfunction

   function automatic logic [C_XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [C_XLEN-1:0] rdata);
      logic [C_XLEN-1:0] sh;
      logic              sx;
      sh = rdata >> {off, 3'b000};
      sx = ~f3[LSU_F3_UNSIGNED];
      case (f3[1:0])
         LSU_SIZE_B: return {{24{sx & sh[7]}}, sh[7:0]};
         LSU_SIZE_H: return {{16{sx & sh[15]}}, sh[15:0]};
         default:    return sh;
      endcase
   endfunction

   assign push       = clk_en_i & (exs_lq_wr_i | exs_sq_wr_i);
   assign busy       = (state_q == LSQ_STATE_BUSY);
   assign pop        = clk_en_i & busy & dmem_ack_i;
   assign last_entry = (count == (C_DEPTH_X+1)'(1));
   assign push_entry = '{is_load:    exs_lq_wr_i,
                         funct3:     exs_funct3_i,
                         regd_addr:  exs_regd_addr_i,
                         regs2_data: exs_regs2_data_i,
                         addr:       exs_addr_i};
   assign head       = lsq_entry_t'(head_raw);

   load_store_queue_fifo #(
      .C_WIDTH   (ENTRY_W),
      .C_DEPTH_X (C_DEPTH_X)
   ) u_fifo (
      .clk_i    (clk_i),
      .resetb_i (resetb_i),
      .push_i   (push),
      .pop_i    (pop),
      .wdata_i  (push_entry),
      .rdata_o  (head_raw),
      .count_o  (count),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   // Memory port mirrors the head entry only while a transaction is outstanding
   assign dmem_req_o     = busy;
   assign dmem_wr_o      = busy & ~head.is_load;
   assign dmem_addr_o    = busy ? {head.addr[C_XLEN-1:2], 2'b00} : '0;
   assign dmem_byte_en_o = busy ? lane_be(head.funct3[1:0], head.addr[1:0]) : '0;
   assign dmem_wdata_o   = busy ? lane_wdata(head.funct3[1:0], head.regs2_data) : '0;

   assign exs_full_o     = fifo_full;
   assign lsq_empty_o    = fifo_empty & ~busy;
   assign wb_regd_data_d = load_extend(head.funct3, head.addr[1:0], dmem_rdata_i);

   always_ff @(posedge clk_i) begin
      if (!resetb_i) begin
         state_q        <= LSQ_STATE_IDLE;
         wb_regd_wr_q   <= 1'b0;
         wb_regd_addr_q <= '0;
         wb_regd_data_q <= '0;
      end else if (clk_en_i) begin
         wb_regd_wr_q <= 1'b0;
         case (state_q)
            LSQ_STATE_IDLE: begin
               if (!fifo_empty) state_q <= LSQ_STATE_BUSY;
            end
            LSQ_STATE_BUSY: begin
               if (dmem_ack_i) begin
                  if (head.is_load) begin
                     wb_regd_wr_q   <= 1'b1;
                     wb_regd_addr_q <= head.regd_addr;
                     wb_regd_data_q <= wb_regd_data_d;
                  end
                  if (last_entry && !push) state_q <= LSQ_STATE_IDLE;
               end
            end
            default: state_q <= LSQ_STATE_IDLE;
         endcase
      end
   end

   assign wb_regd_wr_o   = wb_regd_wr_q;
   assign wb_regd_addr_o = wb_regd_addr_q;
   assign wb_regd_data_o = wb_regd_data_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed and random stimulus for load_store_queue, checked every cycle against a
// transaction-level queue model of the specified behaviour.
module tb_load_store_queue;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic        clk_en = 1'b0;
   logic        lq = 1'b0, sq = 1'b0;
   logic [2:0]  f3 = '0;
   logic [4:0]  rd = '0;
   logic [31:0] sdata = '0, addr = '0;
   logic        exs_full, lsq_empty;
   logic        dmem_req, dmem_wr;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wb_wr;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit          ld;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] d;
      logic [31:0] a;
   } ent_t;

   ent_t        m_q[$];
   bit          m_busy = 0;
   bit          m_wb = 0;
   logic [4:0]  m_wb_rd = '0;
   logic [31:0] m_wb_data = '0;

   load_store_queue dut (
      .clk_i            (clk),
      .resetb_i         (resetb),
      .clk_en_i         (clk_en),
      .exs_lq_wr_i      (lq),
      .exs_sq_wr_i      (sq),
      .exs_funct3_i     (f3),
      .exs_regd_addr_i  (rd),
      .exs_regs2_data_i (sdata),
      .exs_addr_i       (addr),
      .exs_full_o       (exs_full),
      .lsq_empty_o      (lsq_empty),
      .dmem_req_o       (dmem_req),
      .dmem_wr_o        (dmem_wr),
      .dmem_addr_o      (dmem_addr),
      .dmem_byte_en_o   (dmem_be),
      .dmem_wdata_o     (dmem_wdata),
      .dmem_ack_i       (dmem_ack),
      .dmem_rdata_i     (dmem_rdata),
      .wb_regd_wr_o     (wb_wr),
      .wb_regd_addr_o   (wb_addr),
      .wb_regd_data_o   (wb_data)
   );

   always #5 clk = ~clk;

   function automatic int nbytes(logic [2:0] fn);
      return 1 << fn[1:0];
   endfunction

   function automatic logic [3:0] exp_be(ent_t e);
      int v;
      v = ((1 << nbytes(e.f3)) - 1) << int'(e.a[1:0]);
      return v[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(ent_t e);
      case (nbytes(e.f3))
         1:       return {24'd0, e.d[7:0]} * 32'h01010101;
         2:       return {16'd0, e.d[15:0]} * 32'h00010001;
         default: return e.d;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(ent_t e, logic [31:0] rdata);
      int          n;
      logic [31:0] v, mask;
      n    = nbytes(e.f3);
      v    = rdata >> (8 * int'(e.a[1:0]));
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v    = v & mask;
      if (!e.f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      ent_t e;
      chk("full", {31'd0, exs_full}, {31'd0, m_q.size() == 4});
      chk("empty", {31'd0, lsq_empty}, {31'd0, (m_q.size() == 0) && !m_busy});
      chk("req", {31'd0, dmem_req}, {31'd0, m_busy});
      chk("wb_wr", {31'd0, wb_wr}, {31'd0, m_wb});
      if (m_wb) begin
         chk("wb_addr", {27'd0, wb_addr}, {27'd0, m_wb_rd});
         chk("wb_data", wb_data, m_wb_data);
      end
      if (m_busy) begin
         e = m_q[0];
         chk("dmem_wr", {31'd0, dmem_wr}, {31'd0, !e.ld});
         chk("dmem_addr", dmem_addr, e.a & 32'hFFFF_FFFC);
         chk("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be(e)});
         if (!e.ld) chk("dmem_wdata", dmem_wdata, exp_wdata(e));
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then check outputs.
   task automatic tick();
      int   pre;
      bit   was_busy;
      ent_t e, n;
      @(posedge clk);
      if (!resetb) begin
         m_q.delete();
         m_busy = 0;
         m_wb   = 0;
      end else if (clk_en) begin
         pre      = m_q.size();
         was_busy = m_busy;
         m_wb     = 0;
         if (was_busy && dmem_ack) begin
            e = m_q.pop_front();
            if (e.ld) begin
               m_wb      = 1;
               m_wb_rd   = e.rd;
               m_wb_data = exp_load(e, dmem_rdata);
            end
         end
         if ((lq || sq) && m_q.size() < 4) begin
            n.ld = lq; n.f3 = f3; n.rd = rd; n.d = sdata; n.a = addr;
            m_q.push_back(n);
         end
         m_busy = was_busy ? (m_q.size() != 0) : (pre != 0);
      end
      #1;
      check_all();
   endtask

   task automatic set_push(bit ld, logic [2:0] fn, logic [4:0] r, logic [31:0] d, logic [31:0] a);
      lq = ld; sq = !ld; f3 = fn; rd = r; sdata = d; addr = a;
   endtask

   task automatic no_push();
      lq = 0; sq = 0;
   endtask

   task automatic do_reset(bit en);
      resetb = 0; clk_en = en; no_push();
      tick();
      chk("rst_wr", {31'd0, dmem_wr}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_be", {28'd0, dmem_be}, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      resetb = 1; clk_en = 1;
   endtask

   initial begin
      int          k;
      bit          can_pop, uns;
      logic [31:0] a;

      // Reset with clock enable low still takes effect
      #2;
      do_reset(0);
      tick();

      // Store byte to the top lane
      set_push(0, 3'b000, 5'd0, 32'h0000_00A5, 32'h0000_1003);
      tick();
      no_push();
      tick();
      chk("sb_req", {31'd0, dmem_req}, 32'd1);
      chk("sb_addr", dmem_addr, 32'h0000_1000);
      chk("sb_be", {28'd0, dmem_be}, 32'h8);
      chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      chk("sb_wr", {31'd0, dmem_wr}, 32'd1);
      dmem_ack = 1;
      tick();
      chk("sb_nowb", {31'd0, wb_wr}, 32'd0);
      chk("sb_empty", {31'd0, lsq_empty}, 32'd1);
      dmem_ack = 0;

      // Load half, signed then unsigned
      for (int s = 0; s < 2; s++) begin
         set_push(1, (s == 0) ? 3'b001 : 3'b101, 5'd7, 32'd0, 32'h0000_2002);
         tick();
         no_push();
         tick();
         dmem_ack = 1; dmem_rdata = 32'h8001_1234;
         tick();
         dmem_ack = 0;
         chk("lh_wb", {31'd0, wb_wr}, 32'd1);
         chk("lh_rd", {27'd0, wb_addr}, 32'd7);
         chk("lh_data", wb_data, (s == 0) ? 32'hFFFF_8001 : 32'h0000_8001);
         tick();
         chk("lh_pulse", {31'd0, wb_wr}, 32'd0);
      end

      // Fill to full with no acks, then push and pop on the same edge
      for (int i = 0; i < 4; i++) begin
         set_push(0, 3'b010, 5'd0, 32'h1111_0000 + i, 32'h0000_0100 * (i + 1));
         tick();
      end
      chk("fill_full", {31'd0, exs_full}, 32'd1);
      set_push(1, 3'b000, 5'd3, 32'd0, 32'h0000_0901);
      dmem_ack = 1; dmem_rdata = 32'h0000_F000;
      tick();
      chk("pp_full", {31'd0, exs_full}, 32'd1);
      no_push();
      for (int i = 0; i < 4; i++) tick();
      chk("drain_wb", wb_data, 32'hFFFF_FFF0);
      dmem_ack = 0;
      tick();

      // Back-to-back: three entries acked every cycle
      for (int i = 0; i < 3; i++) begin
         set_push(0, 3'b010, 5'd0, 32'hCAFE_0000 + i, 32'h0000_4000 + 4 * i);
         tick();
      end
      no_push();
      dmem_ack = 1;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_req", {31'd0, dmem_req}, 32'd1);
         chk("b2b_addr", dmem_addr, 32'h0000_4000 + 4 * i);
         tick();
      end
      chk("b2b_empty", {31'd0, lsq_empty}, 32'd1);
      dmem_ack = 0;

      // Clock enable low while ack is high
      set_push(1, 3'b100, 5'd9, 32'd0, 32'h0000_3002);
      tick();
      no_push();
      tick();
      clk_en = 0; dmem_ack = 1; dmem_rdata = 32'h0085_0000;
      tick();
      tick();
      chk("stall_req", {31'd0, dmem_req}, 32'd1);
      chk("stall_wb", {31'd0, wb_wr}, 32'd0);
      clk_en = 1;
      tick();
      chk("stall_done", wb_data, 32'h0000_0085);
      tick();
      chk("stall_once", {31'd0, wb_wr}, 32'd0);
      dmem_ack = 0;

      // Reset during a transaction, then a stray ack
      set_push(1, 3'b010, 5'd4, 32'd0, 32'h0000_5000);
      tick();
      set_push(0, 3'b010, 5'd0, 32'h1234_5678, 32'h0000_5004);
      tick();
      no_push();
      chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
      do_reset(1);
      dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("stray_wb", {31'd0, wb_wr}, 32'd0);
      chk("stray_req", {31'd0, dmem_req}, 32'd0);
      dmem_ack = 0;

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         clk_en     = ($urandom_range(0, 9) != 0);
         dmem_ack   = $urandom_range(0, 1);
         dmem_rdata = $urandom;
         can_pop    = m_busy && dmem_ack && clk_en;
         no_push();
         k   = $urandom_range(0, 2);
         uns = (k != 2) && ($urandom_range(0, 1) == 1);
         a   = $urandom;
         if (k >= 1) a[0] = 1'b0;
         if (k == 2) a[1] = 1'b0;
         if ($urandom_range(0, 2) != 0 && (m_q.size() < 4 || can_pop)) begin
            if ($urandom_range(0, 1) == 1) set_push(1, {uns, k[1:0]}, 5'($urandom), 32'd0, a);
            else                           set_push(0, {1'b0, k[1:0]}, 5'd0, $urandom, a);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
